// File: rtl/dircc_board_io.sv
// DE1-SoC front-panel I/O slave: debounced keys with edge IRQ, synced switches, LEDs, blankable hex.
// Readdata latency 1 cycle, no waitrequest; optional heartbeat LED under DIRCC_BOARD_IO_HEARTBEAT_EN.
module dircc_board_io #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int NUM_LEDS        = 10,
    parameter int NUM_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [2:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    irq,
    input  logic [NUM_KEYS-1:0]     key_n,
    input  logic [NUM_SW-1:0]       sw,
    output logic [NUM_LEDS-1:0]     ledr,
    output logic [7*NUM_DIGITS-1:0] hex
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] P_DIG = NUM_DIGITS;
    localparam logic [31:0] P_LED = NUM_LEDS;
    localparam logic [31:0] P_SW  = NUM_SW;
    localparam logic [31:0] P_KEY = NUM_KEYS;
    localparam logic [31:0] INFO  = {8'hD1, P_DIG[3:0], P_LED[4:0], P_SW[4:0], P_KEY[4:0], 5'b0};

    logic [4*NUM_DIGITS-1:0] r_hex_value;
    logic [NUM_DIGITS-1:0]   r_hex_blank;
    logic [NUM_LEDS-1:0]     r_ledr;
    logic [NUM_KEYS-1:0]     r_key_s1, r_key_s2;
    logic [NUM_SW-1:0]       r_sw_s1, r_sw_s2;
    logic [NUM_KEYS-1:0]     r_stable, r_key_edge, r_irq_mask;
    logic [CW-1:0]           r_cnt [NUM_KEYS];
    logic [31:0]             r_rdata;
    logic                    r_irq;

    logic [NUM_KEYS-1:0]     w_pressed, w_stable_nxt, w_rise, w_clr;
    logic [CW-1:0]           w_cnt_nxt [NUM_KEYS];
    logic [NUM_LEDS-1:0]     w_ledr;
    logic [31:0]             w_rdata;
    logic [7*NUM_DIGITS-1:0] w_hex;

    assign w_pressed = ~r_key_s2;

    always_comb begin
        w_stable_nxt = r_stable;
        for (int k = 0; k < NUM_KEYS; k++) begin
            w_cnt_nxt[k] = '0;
            if (w_pressed[k] != r_stable[k]) begin
                if (r_cnt[k] == CNT_MAX) begin
                    w_stable_nxt[k] = w_pressed[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_rise = w_stable_nxt & ~r_stable;
    assign w_clr  = (avs_write && avs_address == 3'd4) ? avs_writedata[NUM_KEYS-1:0] : '0;

`ifdef DIRCC_BOARD_IO_HEARTBEAT_EN
    logic [24:0] r_hb_cnt;
    logic        r_hb;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
            if (&r_hb_cnt) r_hb <= ~r_hb;
        end
    end

    always_comb begin
        w_ledr             = r_ledr;
        w_ledr[NUM_LEDS-1] = r_hb;
    end
`else
    assign w_ledr = r_ledr;
`endif

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            3'd0: w_rdata[4*NUM_DIGITS-1:0] = r_hex_value;
            3'd1: w_rdata[NUM_DIGITS-1:0]   = r_hex_blank;
            3'd2: w_rdata[NUM_LEDS-1:0]     = w_ledr;
            3'd3: w_rdata[NUM_KEYS-1:0]     = r_stable;
            3'd4: w_rdata[NUM_KEYS-1:0]     = r_key_edge;
            3'd5: w_rdata[NUM_KEYS-1:0]     = r_irq_mask;
            3'd6: w_rdata[NUM_SW-1:0]       = r_sw_s2;
            3'd7: w_rdata                   = INFO;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_hex_value <= '0;
            r_hex_blank <= '1;
            r_ledr      <= '0;
            r_key_s1    <= '1;
            r_key_s2    <= '1;
            r_sw_s1     <= '0;
            r_sw_s2     <= '0;
            r_stable    <= '0;
            r_key_edge  <= '0;
            r_irq_mask  <= '0;
            r_rdata     <= '0;
            r_irq       <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
        end else begin
            r_key_s1   <= key_n;
            r_key_s2   <= r_key_s1;
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_stable   <= w_stable_nxt;
            r_cnt      <= w_cnt_nxt;
            // A press arriving in the same cycle as its W1C must not be lost.
            r_key_edge <= (r_key_edge & ~w_clr) | w_rise;
            r_irq      <= |(r_key_edge & r_irq_mask);
            if (avs_read) r_rdata <= w_rdata;
            if (avs_write) begin
                case (avs_address)
                    3'd0: r_hex_value <= avs_writedata[4*NUM_DIGITS-1:0];
                    3'd1: r_hex_blank <= avs_writedata[NUM_DIGITS-1:0];
                    3'd2: r_ledr      <= avs_writedata[NUM_LEDS-1:0];
                    3'd5: r_irq_mask  <= avs_writedata[NUM_KEYS-1:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_hex = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_hex[7*d +: 7] = r_hex_blank[d] ? 7'h7F : glyph(r_hex_value[4*d +: 4]);
        end
    end

    assign hex          = w_hex;
    assign ledr         = w_ledr;
    assign avs_readdata = r_rdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_dircc_board_io.sv
// Randomised self-checking bench for dircc_board_io with a short debounce window.
module tb_dircc_board_io;

    localparam int NK  = 4;
    localparam int NS  = 10;
    localparam int NL  = 10;
    localparam int ND  = 6;
    localparam int DEB = 8;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic [2:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          irq;
    logic [NK-1:0] key_n = '1;
    logic [NS-1:0] sw = '0;
    logic [NL-1:0] ledr;
    logic [7*ND-1:0] hex;

    int total = 0;
    int bad   = 0;

    // Reference state, updated from register-map semantics.
    logic [4*ND-1:0] m_hex_value;
    logic [ND-1:0]   m_hex_blank;
    logic [6:0]      glyphs [16];

    dircc_board_io #(
        .NUM_KEYS(NK), .NUM_SW(NS), .NUM_LEDS(NL), .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
        .key_n(key_n), .sw(sw), .ledr(ledr), .hex(hex)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    function automatic logic [7*ND-1:0] exp_hex();
        logic [7*ND-1:0] r;
        r = '1;
        for (int d = 0; d < ND; d++) begin
            if (m_hex_blank[d]) r[7*d +: 7] = 7'h7F;
            else r[7*d +: 7] = glyphs[(m_hex_value >> (4*d)) & 4'hF];
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] d, info;
        reset_reset = 1'b1;
        repeat (3) tick();
        reset_reset = 1'b0;
        m_hex_value = '0; m_hex_blank = '1;
        total++; if (hex !== {7*ND{1'b1}}) begin bad++; $display("FAIL reset_hex got=%h want=all ones", hex); end
        total++; if (ledr !== '0) begin bad++; $display("FAIL reset_ledr got=%h want=0", ledr); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", avs_readdata); end
        info = {8'hD1, 4'(ND), 5'(NL), 5'(NS), 5'(NK), 5'b0};
        rd(3'd7, d);
        total++; if (d !== info) begin bad++; $display("FAIL info got=%h want=%h", d, info); end
        rd(3'd1, d);
        total++; if (d !== 32'h3F) begin bad++; $display("FAIL reset_blank got=%h want=3f", d); end
        rd(3'd4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h want=0", d); end
    endtask

    task automatic test_hex();
        logic [31:0] d, v, b;
        wr(3'd0, 32'h00A5F0); m_hex_value = 24'h00A5F0;
        wr(3'd1, 32'h0);      m_hex_blank = '0;
        total++; if (hex[6:0] !== 7'h40) begin bad++; $display("FAIL hex_d0 got=%h want=40", hex[6:0]); end
        total++; if (hex[13:7] !== 7'h0E) begin bad++; $display("FAIL hex_d1 got=%h want=0e", hex[13:7]); end
        total++; if (hex !== exp_hex()) begin bad++; $display("FAIL hex_all got=%h want=%h", hex, exp_hex()); end
        wr(3'd1, 32'h2); m_hex_blank = 6'h02;
        total++; if (hex[13:7] !== 7'h7F) begin bad++; $display("FAIL hex_blank1 got=%h want=7f", hex[13:7]); end
        for (int i = 0; i < 6; i++) begin
            v = $urandom; b = $urandom;
            wr(3'd0, v); m_hex_value = v[4*ND-1:0];
            wr(3'd1, b); m_hex_blank = b[ND-1:0];
            total++; if (hex !== exp_hex()) begin bad++; $display("FAIL hex_rand got=%h want=%h", hex, exp_hex()); end
            rd(3'd0, d);
            total++; if (d !== (v & 32'h00FF_FFFF)) begin bad++; $display("FAIL hexval_rb got=%h want=%h", d, v & 32'h00FF_FFFF); end
            rd(3'd1, d);
            total++; if (d !== (b & 32'h3F)) begin bad++; $display("FAIL blank_rb got=%h want=%h", d, b & 32'h3F); end
        end
    endtask

    task automatic test_leds();
        logic [31:0] d, v;
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            wr(3'd2, v);
            total++; if (ledr !== v[NL-1:0]) begin bad++; $display("FAIL ledr got=%h want=%h", ledr, v[NL-1:0]); end
            rd(3'd2, d);
            total++; if (d !== (v & 32'h3FF)) begin bad++; $display("FAIL ledr_rb got=%h want=%h", d, v & 32'h3FF); end
        end
    endtask

    task automatic test_rw_same();
        logic [31:0] d;
        wr(3'd2, 32'h155);
        avs_address = 3'd2; avs_writedata = 32'h2AA; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0;
        total++; if (avs_readdata !== 32'h155) begin bad++; $display("FAIL rw_old got=%h want=155", avs_readdata); end
        rd(3'd2, d);
        total++; if (d !== 32'h2AA) begin bad++; $display("FAIL rw_new got=%h want=2aa", d); end
    endtask

    task automatic test_sw();
        logic [31:0] d;
        logic [NS-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = NS'($urandom);
            sw = v;
            tick(); tick();
            rd(3'd6, d);
            total++; if (d !== 32'(v)) begin bad++; $display("FAIL sw got=%h want=%h", d, v); end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        int k, len;
        key_n[2] = 1'b0;
        repeat (5) tick();
        key_n[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (DEB) tick();
            k = $urandom_range(0, NK-1);
            len = $urandom_range(1, DEB-1);
            key_n[k] = 1'b0;
            repeat (len) tick();
            key_n[k] = 1'b1;
        end
        repeat (DEB + 4) tick();
        rd(3'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_state got=%h want=0", d); end
        rd(3'd4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_edge got=%h want=0", d); end
        // Continuous read of KEY_STATE: readdata lags the register by one cycle.
        avs_address = 3'd3; avs_read = 1'b1;
        key_n[2] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= DEB + 5) begin
                total++;
                if (avs_readdata[2] !== (i >= DEB + 3)) begin
                    bad++; $display("FAIL press_timing cyc=%0d got=%b want=%b", i, avs_readdata[2], i >= DEB + 3);
                end
            end
        end
        avs_read = 1'b0;
        rd(3'd4, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL press_edge got=%h want=4", d); end
        key_n[2] = 1'b1;
        repeat (DEB + 4) tick();
        rd(3'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL release_state got=%h want=0", d); end
        rd(3'd4, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL release_edge got=%h want=4", d); end
    endtask

    task automatic test_irq();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", irq); end
        wr(3'd5, 32'h4);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b want=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
        wr(3'd4, 32'h4);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want=1", irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_drop got=%b want=0", irq); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        key_n[1] = 1'b0;
        repeat (DEB + 1) tick();
        wr(3'd4, 32'h2);
        rd(3'd4, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL collide got=%h want=2", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL collide_irq got=%b want=0", irq); end
        key_n[1] = 1'b1;
        wr(3'd4, 32'h2);
        rd(3'd4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c got=%h want=0", d); end
        repeat (DEB + 4) tick();
    endtask

    task automatic test_reset_read();
        logic [31:0] d;
        wr(3'd2, 32'h3C3);
        rd(3'd2, d);
        total++; if (d !== 32'h3C3) begin bad++; $display("FAIL pre_reset got=%h want=3c3", d); end
        key_n[0] = 1'b0;
        repeat (DEB - 2) tick();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        m_hex_value = '0; m_hex_blank = '1;
        total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", avs_readdata); end
        total++; if (ledr !== '0) begin bad++; $display("FAIL rst_ledr got=%h want=0", ledr); end
        total++; if (hex !== exp_hex()) begin bad++; $display("FAIL rst_hex got=%h want=%h", hex, exp_hex()); end
        rd(3'd3, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_keystate got=%h want=0", d); end
        key_n[0] = 1'b1;
    endtask

    initial begin
        glyphs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_hex();
        test_leds();
        test_rw_same();
        test_sw();
        test_debounce();
        test_irq();
        test_collision();
        test_reset_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
